// File: rtl/dqn_sequencer.sv
// -----------------------------------------------------------------------------
// dqn_sequencer
//
// Front-end sequencer for a DQN accelerator with a main network and a target
// network. It has four operating modes:
//
//   INIT  - initial weight load: weight writes are forwarded to both networks.
//   RUN   - interactive inference: the current state of each sample is
//           serialised, one element per cycle, to the main network only.
//   TRAIN - training: current state goes to the main network and next state
//           to the target network, element by element. Every UPDATE_PERIOD
//           training samples it requests a main->target weight synchronisation.
//   SYNC  - the external synchronisation engine reads main weights and writes
//           target weights through the shared weight bus.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid / o_ready     sample handshake (accepted when both are high)
//   i_current_state       N packed elements, element k at [k*DW +: DW]
//   i_next_state          N packed elements, same packing
//   i_train_mode          level: 1 = training, 0 = interactive
//   i_weight_*            initial-load weight strobe, layer, address, value
//   i_load_weight_done    initial load complete pulse
//   i_sync_*              sync engine strobe, read/write, layer, addr, value
//   i_sync_done           synchronisation complete pulse
//   o_data_valid          element strobe, bit0 = main, bit1 = target
//   o_data_addr           element index
//   o_data                {target element, main element}
//   o_wt_valid            weight strobe, bit0 = main, bit1 = target
//   o_wt_layer/addr/data  shared weight bus
//   o_load_done           load-done pulse, bit0 = main, bit1 = target
//   o_update_request      one-cycle synchronisation start pulse
//   o_mode                0 INIT, 1 RUN, 2 TRAIN, 3 SYNC
// -----------------------------------------------------------------------------
module dqn_sequencer #(
    parameter int DATA_WIDTH           = 32,
    parameter int LAYER_WIDTH          = 2,
    parameter int WEIGHT_ADDR_WIDTH    = 11,
    parameter int NUMBER_OF_INPUT_NODE = 2,
    parameter int UPDATE_PERIOD        = 4,
    localparam int ADDR_W = (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_current_state,
    input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_next_state,
    input  logic                                       i_train_mode,
    input  logic                                       i_weight_valid,
    input  logic [LAYER_WIDTH-1:0]                     i_weight_layer,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]               i_weight_addr,
    input  logic [DATA_WIDTH-1:0]                      i_weight,
    input  logic                                       i_load_weight_done,
    input  logic                                       i_sync_valid,
    input  logic                                       i_sync_wr,
    input  logic [LAYER_WIDTH-1:0]                     i_sync_layer,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]               i_sync_addr,
    input  logic [DATA_WIDTH-1:0]                      i_sync_weight,
    input  logic                                       i_sync_done,
    output logic [1:0]                                 o_data_valid,
    output logic [ADDR_W-1:0]                          o_data_addr,
    output logic [2*DATA_WIDTH-1:0]                    o_data,
    output logic [1:0]                                 o_wt_valid,
    output logic [LAYER_WIDTH-1:0]                     o_wt_layer,
    output logic [WEIGHT_ADDR_WIDTH-1:0]               o_wt_addr,
    output logic [DATA_WIDTH-1:0]                      o_wt_data,
    output logic [1:0]                                 o_load_done,
    output logic                                       o_update_request,
    output logic [1:0]                                 o_mode
);

    localparam int N     = NUMBER_OF_INPUT_NODE;
    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(UPDATE_PERIOD + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(UPDATE_PERIOD);

    typedef enum logic [1:0] {
        MODE_INIT  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_TRAIN = 2'd2,
        MODE_SYNC  = 2'd3
    } mode_t;

    mode_t             mode_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] idx_reg;          // index of the element currently on o_data
    logic [CNT_W-1:0]  sample_cnt_reg;   // training samples since last sync
    logic [N*DW-1:0]   cur_reg;
    logic [N*DW-1:0]   nxt_reg;

    logic [ADDR_W-1:0] idx_next;
    logic [DW-1:0]     cur_elem [N];
    logic [DW-1:0]     nxt_elem [N];

    // Unpack the captured sample so the serialiser can index by element.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign cur_elem[gi] = cur_reg[gi*DW +: DW];
            assign nxt_elem[gi] = nxt_reg[gi*DW +: DW];
        end
    endgenerate

    assign idx_next = idx_reg + ADDR_W'(1);

    // Ready is a pure function of registered state, so it drops the cycle
    // after acceptance and rises again the cycle after the last element.
    assign o_ready = ((mode_reg == MODE_RUN) || (mode_reg == MODE_TRAIN)) && !busy_reg;
    assign o_mode  = mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg         <= MODE_INIT;
            busy_reg         <= 1'b0;
            idx_reg          <= '0;
            sample_cnt_reg   <= '0;
            cur_reg          <= '0;
            nxt_reg          <= '0;
            o_data_valid     <= 2'b00;
            o_data_addr      <= '0;
            o_data           <= '0;
            o_wt_valid       <= 2'b00;
            o_wt_layer       <= '0;
            o_wt_addr        <= '0;
            o_wt_data        <= '0;
            o_load_done      <= 2'b00;
            o_update_request <= 1'b0;
        end else begin
            // Strobes and pulses default low; the mode branches raise them.
            o_wt_valid       <= 2'b00;
            o_load_done      <= 2'b00;
            o_update_request <= 1'b0;

            case (mode_reg)
                MODE_INIT: begin
                    if (i_weight_valid) begin
                        o_wt_valid <= 2'b11;
                        o_wt_layer <= i_weight_layer;
                        o_wt_addr  <= i_weight_addr;
                        o_wt_data  <= i_weight;
                    end
                    if (i_load_weight_done) begin
                        o_load_done <= 2'b11;
                        mode_reg    <= MODE_RUN;
                    end
                end

                MODE_RUN, MODE_TRAIN: begin
                    if (busy_reg) begin
                        if (idx_reg == LAST_IDX) begin
                            // Last element has been presented for one cycle.
                            busy_reg     <= 1'b0;
                            o_data_valid <= 2'b00;
                            o_data_addr  <= '0;
                            o_data       <= '0;
                            // The counter can only have reached the limit via
                            // the sample just finished, so the sync request
                            // follows that sample's last element.
                            if (sample_cnt_reg == CNT_LIMIT) begin
                                o_update_request <= 1'b1;
                                sample_cnt_reg   <= '0;
                                mode_reg         <= MODE_SYNC;
                            end
                        end else begin
                            idx_reg     <= idx_next;
                            o_data_addr <= idx_next;
                            o_data      <= {nxt_elem[idx_next], cur_elem[idx_next]};
                        end
                    end else begin
                        // Mode tracks the train level only between samples,
                        // so a sample is never split across modes.
                        mode_reg <= i_train_mode ? MODE_TRAIN : MODE_RUN;
                        if (i_valid) begin
                            cur_reg      <= i_current_state;
                            nxt_reg      <= i_next_state;
                            busy_reg     <= 1'b1;
                            idx_reg      <= '0;
                            o_data_addr  <= '0;
                            // Element 0 comes straight from the inputs so it
                            // appears the cycle after acceptance.
                            o_data       <= {i_next_state[DW-1:0], i_current_state[DW-1:0]};
                            o_data_valid <= (mode_reg == MODE_TRAIN) ? 2'b11 : 2'b01;
                            if (mode_reg == MODE_TRAIN) begin
                                sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                end

                MODE_SYNC: begin
                    if (i_sync_valid) begin
                        o_wt_layer <= i_sync_layer;
                        o_wt_addr  <= i_sync_addr;
                        if (i_sync_wr) begin
                            // Write goes to the target network only.
                            o_wt_valid <= 2'b10;
                            o_wt_data  <= i_sync_weight;
                        end else begin
                            // Read request: data bus is left as is.
                            o_wt_valid <= 2'b11;
                        end
                    end
                    if (i_sync_done) begin
                        o_load_done <= 2'b10;
                        mode_reg    <= i_train_mode ? MODE_TRAIN : MODE_RUN;
                    end
                end

                default: mode_reg <= MODE_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dqn_sequencer.sv
module tb_dqn_sequencer;

    localparam int DW  = 32;
    localparam int LW  = 2;
    localparam int WAW = 11;
    localparam int N   = 3;
    localparam int UP  = 2;

    localparam logic [DW-1:0] EA = 32'hA0A0A0A0;
    localparam logic [DW-1:0] EB = 32'hB1B1B1B1;
    localparam logic [DW-1:0] EC = 32'hC2C2C2C2;
    localparam logic [DW-1:0] ED = 32'hD3D3D3D3;
    localparam logic [DW-1:0] EE = 32'hE4E4E4E4;
    localparam logic [DW-1:0] EF = 32'hF5F5F5F5;
    localparam logic [N*DW-1:0] CUR = {EC, EB, EA};
    localparam logic [N*DW-1:0] NXT = {EF, EE, ED};

    logic                clk = 1'b0;
    logic                rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [N*DW-1:0]     i_current_state;
    logic [N*DW-1:0]     i_next_state;
    logic                i_train_mode;
    logic                i_weight_valid;
    logic [LW-1:0]       i_weight_layer;
    logic [WAW-1:0]      i_weight_addr;
    logic [DW-1:0]       i_weight;
    logic                i_load_weight_done;
    logic                i_sync_valid;
    logic                i_sync_wr;
    logic [LW-1:0]       i_sync_layer;
    logic [WAW-1:0]      i_sync_addr;
    logic [DW-1:0]       i_sync_weight;
    logic                i_sync_done;
    logic [1:0]          o_data_valid;
    logic [1:0]          o_data_addr;
    logic [2*DW-1:0]     o_data;
    logic [1:0]          o_wt_valid;
    logic [LW-1:0]       o_wt_layer;
    logic [WAW-1:0]      o_wt_addr;
    logic [DW-1:0]       o_wt_data;
    logic [1:0]          o_load_done;
    logic                o_update_request;
    logic [1:0]          o_mode;

    dqn_sequencer #(
        .DATA_WIDTH(DW), .LAYER_WIDTH(LW), .WEIGHT_ADDR_WIDTH(WAW),
        .NUMBER_OF_INPUT_NODE(N), .UPDATE_PERIOD(UP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_current_state(i_current_state), .i_next_state(i_next_state),
        .i_train_mode(i_train_mode),
        .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer),
        .i_weight_addr(i_weight_addr), .i_weight(i_weight),
        .i_load_weight_done(i_load_weight_done),
        .i_sync_valid(i_sync_valid), .i_sync_wr(i_sync_wr),
        .i_sync_layer(i_sync_layer), .i_sync_addr(i_sync_addr),
        .i_sync_weight(i_sync_weight), .i_sync_done(i_sync_done),
        .o_data_valid(o_data_valid), .o_data_addr(o_data_addr), .o_data(o_data),
        .o_wt_valid(o_wt_valid), .o_wt_layer(o_wt_layer), .o_wt_addr(o_wt_addr),
        .o_wt_data(o_wt_data), .o_load_done(o_load_done),
        .o_update_request(o_update_request), .o_mode(o_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic            valid;
        logic            train;
        logic            wv;
        logic [LW-1:0]   wl;
        logic [WAW-1:0]  wa;
        logic [DW-1:0]   w;
        logic            wdone;
        logic            sv;
        logic            swr;
        logic [LW-1:0]   sl;
        logic [WAW-1:0]  sa;
        logic [DW-1:0]   sw;
        logic            sdone;
        logic [N*DW-1:0] cur;
        logic [N*DW-1:0] nxt;
        // expected outputs after the clock edge
        logic            e_ready;
        logic [1:0]      e_dv;
        logic [1:0]      e_daddr;
        logic [2*DW-1:0] e_data;
        logic [1:0]      e_wtv;
        logic [LW-1:0]   e_wtl;
        logic [WAW-1:0]  e_wta;
        logic [DW-1:0]   e_wtd;
        logic [1:0]      e_ld;
        logic            e_upd;
        logic [1:0]      e_mode;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;
    vec_t r;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input vec_t v, input string name);
        logic [120:0] act;
        logic [120:0] exp;
        act = {o_ready, o_data_valid, o_data_addr, o_data, o_wt_valid, o_wt_layer,
               o_wt_addr, o_wt_data, o_load_done, o_update_request, o_mode};
        exp = {v.e_ready, v.e_dv, v.e_daddr, v.e_data, v.e_wtv, v.e_wtl,
               v.e_wta, v.e_wtd, v.e_ld, v.e_upd, v.e_mode};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got rdy=%b dv=%b da=%0d d=%h wtv=%b wtl=%0d wta=%0d wtd=%h ld=%b upd=%b mode=%0d, expected rdy=%b dv=%b da=%0d d=%h wtv=%b wtl=%0d wta=%0d wtd=%h ld=%b upd=%b mode=%0d",
                     name, o_ready, o_data_valid, o_data_addr, o_data, o_wt_valid, o_wt_layer,
                     o_wt_addr, o_wt_data, o_load_done, o_update_request, o_mode,
                     v.e_ready, v.e_dv, v.e_daddr, v.e_data, v.e_wtv, v.e_wtl,
                     v.e_wta, v.e_wtd, v.e_ld, v.e_upd, v.e_mode);
        end else begin
            $display("[TB] %s ok: mode=%0d dv=%b da=%0d wtv=%b", name, o_mode,
                     o_data_valid, o_data_addr, o_wt_valid);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        i_valid            = v.valid;
        i_train_mode       = v.train;
        i_weight_valid     = v.wv;
        i_weight_layer     = v.wl;
        i_weight_addr      = v.wa;
        i_weight           = v.w;
        i_load_weight_done = v.wdone;
        i_sync_valid       = v.sv;
        i_sync_wr          = v.swr;
        i_sync_layer       = v.sl;
        i_sync_addr        = v.sa;
        i_sync_weight      = v.sw;
        i_sync_done        = v.sdone;
        i_current_state    = v.cur;
        i_next_state       = v.nxt;
        @(posedge clk);
        #1;
        check(v, name);
    endtask

    // Strobes and pulse expectations return to idle after every step; levels
    // (train, ready, mode, weight bus contents) carry over.
    task automatic clear_pulses();
        r.valid = 0; r.wv = 0; r.wdone = 0; r.sv = 0; r.swr = 0; r.sdone = 0;
        r.e_dv = 0; r.e_daddr = 0; r.e_data = '0; r.e_wtv = 0; r.e_ld = 0; r.e_upd = 0;
    endtask

    task automatic push();
        vecs[nvec] = r;
        nvec++;
        clear_pulses();
    endtask

    task automatic step(input string name);
        run_vec(r, name);
        clear_pulses();
    endtask

    task automatic zero_expect();
        r.e_ready = 0; r.e_dv = 0; r.e_daddr = 0; r.e_data = '0; r.e_wtv = 0;
        r.e_wtl = 0; r.e_wta = 0; r.e_wtd = 0; r.e_ld = 0; r.e_upd = 0; r.e_mode = 0;
    endtask

    // One training sample of CUR/NXT through to the cycle after its last element.
    task automatic train_sample(input logic upd_at_end, input string tag);
        r.valid = 1; r.cur = CUR; r.nxt = NXT; r.e_ready = 0;
        r.e_dv = 2'b11; r.e_daddr = 0; r.e_data = {ED, EA}; step({tag, "_e0"});
        r.e_dv = 2'b11; r.e_daddr = 1; r.e_data = {EE, EB}; step({tag, "_e1"});
        r.e_dv = 2'b11; r.e_daddr = 2; r.e_data = {EF, EC}; step({tag, "_e2"});
        r.e_ready = 1; r.e_upd = upd_at_end; step({tag, "_end"});
    endtask

    initial begin
        r = '{default: '0};
        rst_n = 1'b0;
        i_valid = 0; i_train_mode = 0; i_weight_valid = 0; i_weight_layer = '0;
        i_weight_addr = '0; i_weight = '0; i_load_weight_done = 0; i_sync_valid = 0;
        i_sync_wr = 0; i_sync_layer = '0; i_sync_addr = '0; i_sync_weight = '0;
        i_sync_done = 0; i_current_state = '0; i_next_state = '0;

        // ---------------- vector table ----------------
        // INIT weight write and ignored out-of-mode inputs
        r.wv = 1; r.wl = 1; r.wa = 5; r.w = 32'h3F800000;
        r.e_wtv = 2'b11; r.e_wtl = 1; r.e_wta = 5; r.e_wtd = 32'h3F800000; push();
        push();
        r.valid = 1; r.sv = 1; r.swr = 1; r.sa = 9; r.sw = 32'h55; push();
        r.wdone = 1; r.e_ld = 2'b11; r.e_mode = 1; r.e_ready = 1; push();
        push();
        // RUN sample, weight strobe ignored, i_valid mid-sample dropped
        r.valid = 1; r.cur = CUR; r.nxt = NXT; r.wv = 1; r.wa = 11'h33;
        r.e_ready = 0; r.e_dv = 2'b01; r.e_daddr = 0; r.e_data = {ED, EA}; push();
        r.e_dv = 2'b01; r.e_daddr = 1; r.e_data = {EE, EB}; push();
        r.valid = 1; r.cur = 96'h1; r.nxt = 96'h2;
        r.e_dv = 2'b01; r.e_daddr = 2; r.e_data = {EF, EC}; push();
        r.e_ready = 1; push();
        // switch to TRAIN, two samples, second one triggers sync
        r.train = 1; r.e_mode = 2; push();
        for (int s = 0; s < 2; s++) begin
            r.valid = 1; r.cur = CUR; r.nxt = NXT; r.e_ready = 0;
            r.e_dv = 2'b11; r.e_daddr = 0; r.e_data = {ED, EA}; push();
            r.e_dv = 2'b11; r.e_daddr = 1; r.e_data = {EE, EB}; push();
            r.e_dv = 2'b11; r.e_daddr = 2; r.e_data = {EF, EC}; push();
            if (s == 1) begin
                r.e_upd = 1; r.e_mode = 3; r.e_ready = 0;
            end else begin
                r.e_ready = 1;
            end
            push();
        end
        // SYNC: read (data held), write, ignored weight strobe, done + write
        r.valid = 1; r.sv = 1; r.swr = 0; r.sl = 2; r.sa = 7; r.sw = 32'h12345678;
        r.e_wtv = 2'b11; r.e_wtl = 2; r.e_wta = 7; push();
        r.sv = 1; r.swr = 1; r.sw = 32'h40000000; r.e_wtv = 2'b10; r.e_wtd = 32'h40000000; push();
        r.wv = 1; r.wa = 1; push();
        r.sdone = 1; r.sv = 1; r.swr = 1; r.sl = 3; r.sa = 8; r.sw = 32'hDEADBEEF;
        r.e_ld = 2'b10; r.e_mode = 2; r.e_ready = 1;
        r.e_wtv = 2'b10; r.e_wtl = 3; r.e_wta = 8; r.e_wtd = 32'hDEADBEEF; push();
        push();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        begin
            vec_t z;
            z = '{default: '0};
            check(z, "reset_state");
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- reset mid-serialisation ----------------
        r = vecs[nvec-1];
        clear_pulses();
        train_sample(1'b0, "cnt1");
        r.valid = 1; r.cur = CUR; r.nxt = NXT; r.e_ready = 0;
        r.e_dv = 2'b11; r.e_daddr = 0; r.e_data = {ED, EA}; step("pre_rst_e0");
        r.e_dv = 2'b11; r.e_daddr = 1; r.e_data = {EE, EB}; step("pre_rst_e1");
        rst_n = 1'b0;
        #1;
        zero_expect();
        check(r, "rst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r.valid = 1; r.cur = CUR; r.nxt = NXT; step("init_valid_ignored0");
        r.valid = 1; step("init_valid_ignored1");
        r.wdone = 1; r.e_ld = 2'b11; r.e_mode = 1; r.e_ready = 1; step("init_done2");
        r.e_mode = 2; step("to_train2");
        // counter was cleared by reset, so one sample must not request sync
        train_sample(1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dqn_sequencer.md
DQN_SEQUENCER -- requirements
Module: dqn_sequencer
Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the width of one state element and one weight word.
REQ-002 Parameter LAYER_WIDTH, default 2, SHALL be the weight layer select width.
REQ-003 Parameter WEIGHT_ADDR_WIDTH, default 11, SHALL be the weight address width.
REQ-004 Parameter NUMBER_OF_INPUT_NODE (N), default 2, legal 1..16, SHALL be the number of state elements per sample.
REQ-005 Parameter UPDATE_PERIOD, default 4, legal >=1, SHALL be the number of training samples between weight synchronisations.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_valid  in  1  sample valid; accepted when i_valid && o_ready.
REQ-009 o_ready  out  1  sequencer can accept a sample.
REQ-010 i_current_state  in  N*DATA_WIDTH  current state; element k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 i_next_state  in  N*DATA_WIDTH  next state, same packing.
REQ-012 i_train_mode  in  1  level; 1 = training, 0 = interactive.
REQ-013 i_weight_valid  in  1  initial-load weight strobe.
REQ-014 i_weight_layer / i_weight_addr / i_weight  in  LAYER_WIDTH / WEIGHT_ADDR_WIDTH / DATA_WIDTH  initial-load weight layer, address, value.
REQ-015 i_load_weight_done  in  1  initial load complete pulse.
REQ-016 i_sync_valid  in  1  synchronisation-engine transfer strobe.
REQ-017 i_sync_wr  in  1  with i_sync_valid: 0 = read request, 1 = write.
REQ-018 i_sync_layer / i_sync_addr / i_sync_weight  in  LAYER_WIDTH / WEIGHT_ADDR_WIDTH / DATA_WIDTH  sync layer, address, write value.
REQ-019 i_sync_done  in  1  synchronisation complete pulse.
REQ-020 o_data_valid  out  2  element strobe; bit0 = main net, bit1 = target net.
REQ-021 o_data_addr  out  clog2(N) (min 1)  element index.
REQ-022 o_data  out  2*DATA_WIDTH  [DW-1:0] main element (current state), [2DW-1:DW] target element (next state).
REQ-023 o_wt_valid  out  2  weight strobe; bit0 = main, bit1 = target.
REQ-024 o_wt_layer / o_wt_addr / o_wt_data  out  LAYER_WIDTH / WEIGHT_ADDR_WIDTH / DATA_WIDTH  shared weight bus.
REQ-025 o_load_done  out  2  load-done pulse; bit0 = main, bit1 = target.
REQ-026 o_update_request  out  1  one-cycle synchronisation start pulse.
REQ-027 o_mode  out  2  0 INIT, 1 RUN, 2 TRAIN, 3 SYNC.
Function
REQ-028 INIT: i_weight_* registered to o_wt_* with o_wt_valid = {2{i_weight_valid}}, latency 1; i_load_weight_done -> o_load_done = 2'b11 for 1 cycle, next mode RUN; o_ready = 0.
REQ-029 RUN/TRAIN: o_ready = !busy; acceptance at cycle t captures both vectors and sets busy; element k is driven in cycle t+1+k, k = 0..N-1, o_data_addr = k; busy clears after k = N-1, so o_ready returns at t+N+1.
REQ-030 o_data_valid = 2'b01 in RUN, 2'b11 in TRAIN, 2'b00 otherwise; i_valid while busy is ignored, not queued.
REQ-031 Mode change RUN<->TRAIN follows i_train_mode, only when not busy.
REQ-032 Sample counter (width clog2(UPDATE_PERIOD+1)) increments per TRAIN acceptance; it is retained across RUN/TRAIN.
REQ-033 When the count reaches UPDATE_PERIOD, after the last element of that sample: o_update_request pulses 1 cycle, counter clears, mode -> SYNC.
REQ-034 SYNC: o_ready = 0; read request -> o_wt_valid = 2'b11 with layer/addr, o_wt_data held; write -> o_wt_valid = 2'b10 with layer/addr/data; latency 1.
REQ-035 i_sync_done -> o_load_done = 2'b10 for 1 cycle, mode -> TRAIN if i_train_mode else RUN; a same-cycle i_sync_valid is still forwarded.
REQ-036 Out-of-mode inputs (i_weight_*/i_load_weight_done outside INIT, i_sync_* outside SYNC, i_valid in INIT/SYNC) are ignored; o_wt_valid = 0 in RUN/TRAIN.
Reset
REQ-037 rst_n low at any time, including mid-serialisation or SYNC: all outputs 0, mode INIT, busy 0, counter 0.
Verification
REQ-038 Reset; INIT write layer 1 addr 5 data 0x3F800000 -> next cycle o_wt_valid = 11 with same values; done pulse -> o_load_done = 11 for 1 cycle, o_mode = 1.
REQ-039 N=3, RUN, accept current {C,B,A} -> o_data_valid = 01, addr 0/1/2, data A/B/C at t+1..t+3; o_ready low t+1..t+3; i_valid at t+2 dropped.
REQ-040 TRAIN, UPDATE_PERIOD = 2, two samples -> o_data_valid = 11 per element, o_update_request after 2nd sample's last element, o_mode = 3, o_ready = 0.
REQ-041 SYNC read addr 7 -> o_wt_valid = 11; write 0x40000000 addr 7 -> 10; i_sync_done with i_train_mode = 1 -> o_load_done = 10, o_mode = 2.
REQ-042 rst_n low at element 1 of a sample -> all outputs 0 and o_mode = 0 immediately; later i_valid ignored until init done.
